instruction_serializer: RTL and testbench

Host-side counterpart of the SPI instruction decoder. It accepts one command (instruction, address, value) over a valid/ready handshake and packs it into the TitanComms byte framing, MSB first. It drives the bytes one at a time into an SPI master and collects the bytes returned on MISO into a 32-bit response. It sits between the test/host controller logic and the SPI master, and is used for loopback verification of the FPGA-side command path.

---
 rtl/instruction_serializer_pkg.sv | 56 +++++
 rtl/instruction_serializer.sv | 153 +++++++++++++++
 tb/tb_instruction_serializer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_serializer_pkg.sv
// ---------------------------------------------------------------------------
// instruction_serializer_pkg
//
// Purpose: shared TitanComms definitions for the host-side serializer.
//   - opcode encoding (opcode_e)
//   - serializer FSM state encoding (state_e)
//   - frame sizing constants (FRAME_BYTES_MAX, FRAME_BITS)
//   - instruction_length(): bytes on the wire for an opcode, 0 if illegal.
//     The FPGA-side decoder uses the same function so both ends agree on
//     the framing of every opcode.
// ---------------------------------------------------------------------------
package instruction_serializer_pkg;

    localparam int FRAME_BYTES_MAX = 8;
    localparam int FRAME_BITS      = FRAME_BYTES_MAX * 8;
    // Wide enough to hold FRAME_BYTES_MAX itself.
    localparam int BYTE_COUNT_W    = $clog2(FRAME_BYTES_MAX + 1);

    typedef logic [BYTE_COUNT_W-1:0] byte_count_t;

    typedef enum logic [7:0] {
        OP_WRITE              = 8'h01,
        OP_READ               = 8'h02,
        OP_STREAM             = 8'h03,
        OP_TRANSFER           = 8'h04,
        OP_REPEAT             = 8'h05,
        OP_BIND_INTERRUPT     = 8'h06,
        OP_BIND_READ_ADDRESS  = 8'h07,
        OP_BIND_WRITE_ADDRESS = 8'h08
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_RX = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Number of bytes in the frame for an opcode; 0 marks an illegal opcode.
    function automatic byte_count_t instruction_length(input logic [7:0] opcode);
        byte_count_t len;
        case (opcode)
            OP_WRITE:              len = byte_count_t'(8);
            OP_READ,
            OP_BIND_INTERRUPT,
            OP_BIND_READ_ADDRESS,
            OP_BIND_WRITE_ADDRESS: len = byte_count_t'(4);
            OP_STREAM:             len = byte_count_t'(5);
            OP_TRANSFER,
            OP_REPEAT:             len = byte_count_t'(1);
            default:               len = byte_count_t'(0);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instruction_serializer.sv
// ---------------------------------------------------------------------------
// instruction_serializer
//
// Purpose: accepts one TitanComms command (instruction, address, value) over
// a valid/ready handshake, packs it MSB-first into a left-aligned 64-bit
// shift register and feeds it byte by byte to an SPI master. Bytes returned
// on MISO are collected into a 32-bit response (last four bytes received,
// first-received in the top byte). Exactly one byte is in flight at a time.
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_instruction     TitanComms opcode
//   cmd_address         target address
//   cmd_value           write/stream value
//   spi_tx_valid/ready  byte handshake towards the SPI master
//   spi_tx_byte         byte to shift out (held until spi_tx_ready)
//   spi_rx_valid        single-cycle pulse: exchange done, spi_rx_byte valid
//   spi_rx_byte         byte received in that exchange
//   resp_valid          one-cycle pulse at command completion
//   resp_value          response register
//   busy                command in progress
//   err_illegal         one-cycle pulse after accepting an illegal opcode
// ---------------------------------------------------------------------------
module instruction_serializer
    import instruction_serializer_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 8,
    parameter int ADDRESS_WIDTH     = 24,
    parameter int VALUE_WIDTH       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] cmd_instruction,
    input  logic [ADDRESS_WIDTH-1:0]     cmd_address,
    input  logic [VALUE_WIDTH-1:0]       cmd_value,
    output logic                         spi_tx_valid,
    input  logic                         spi_tx_ready,
    output logic [7:0]                   spi_tx_byte,
    input  logic                         spi_rx_valid,
    input  logic [7:0]                   spi_rx_byte,
    output logic                         resp_valid,
    output logic [VALUE_WIDTH-1:0]       resp_value,
    output logic                         busy,
    output logic                         err_illegal
);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [FRAME_BITS-1:0]   frame_packed;
    byte_count_t             count_q, count_d;
    byte_count_t             frame_len;
    logic [VALUE_WIDTH-1:0]  resp_q, resp_d;
    logic                    err_q, err_d;
    logic                    cmd_fire;

    assign cmd_fire  = cmd_valid && (state_q == ST_IDLE);
    assign frame_len = instruction_length(cmd_instruction);

    // Frame packing: fields left-aligned, unused low bytes zero.
    always_comb begin
        frame_packed = '0;
        case (cmd_instruction)
            OP_WRITE:
                frame_packed = {cmd_instruction, cmd_address, cmd_value};
            OP_READ,
            OP_BIND_INTERRUPT,
            OP_BIND_READ_ADDRESS,
            OP_BIND_WRITE_ADDRESS:
                frame_packed = {cmd_instruction, cmd_address, {VALUE_WIDTH{1'b0}}};
            OP_STREAM:
                frame_packed = {cmd_instruction, cmd_value, {ADDRESS_WIDTH{1'b0}}};
            OP_TRANSFER,
            OP_REPEAT:
                frame_packed = {cmd_instruction, {(FRAME_BITS-INSTRUCTION_WIDTH){1'b0}}};
            default:
                frame_packed = '0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        resp_d  = resp_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (frame_len == '0) begin
                        // Consume the command but send nothing.
                        err_d = 1'b1;
                    end else begin
                        shreg_d = frame_packed;
                        count_d = frame_len;
                        resp_d  = '0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                // An rx pulse coinciding with tx_ready here is deliberately dropped.
                if (spi_tx_ready) begin
                    shreg_d = {shreg_q[FRAME_BITS-9:0], 8'h00};
                    state_d = ST_WAIT_RX;
                end
            end
            ST_WAIT_RX: begin
                if (spi_rx_valid) begin
                    resp_d  = {resp_q[VALUE_WIDTH-9:0], spi_rx_byte};
                    count_d = count_q - byte_count_t'(1);
                    state_d = (count_q == byte_count_t'(1)) ? ST_DONE : ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            count_q <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    // Outputs are direct decodes of registered state, so reset takes effect
    // on them immediately.
    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign spi_tx_valid = (state_q == ST_SEND);
    assign spi_tx_byte  = shreg_q[FRAME_BITS-1 -: 8];
    assign resp_valid   = (state_q == ST_DONE);
    assign resp_value   = resp_q;
    assign err_illegal  = err_q;

endmodule

// File: tb/tb_instruction_serializer.sv
// ---------------------------------------------------------------------------
// tb_instruction_serializer
//
// Randomized bench for instruction_serializer. The bench plays the SPI
// master, drives commands and compares the DUT against a reference model
// that builds the expected frame as a byte queue from the opcode's field
// layout and derives the response from the last four bytes returned.
// ---------------------------------------------------------------------------
module tb_instruction_serializer;
    import instruction_serializer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_instruction;
    logic [23:0] cmd_address;
    logic [31:0] cmd_value;
    logic        spi_tx_valid;
    logic        spi_tx_ready;
    logic [7:0]  spi_tx_byte;
    logic        spi_rx_valid;
    logic [7:0]  spi_rx_byte;
    logic        resp_valid;
    logic [31:0] resp_value;
    logic        busy;
    logic        err_illegal;

    instruction_serializer #(
        .INSTRUCTION_WIDTH (8),
        .ADDRESS_WIDTH     (24),
        .VALUE_WIDTH       (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_instruction (cmd_instruction),
        .cmd_address     (cmd_address),
        .cmd_value       (cmd_value),
        .spi_tx_valid    (spi_tx_valid),
        .spi_tx_ready    (spi_tx_ready),
        .spi_tx_byte     (spi_tx_byte),
        .spi_rx_valid    (spi_rx_valid),
        .spi_rx_byte     (spi_rx_byte),
        .resp_valid      (resp_valid),
        .resp_value      (resp_value),
        .busy            (busy),
        .err_illegal     (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          resp_count   = 0;
    logic [31:0] last_resp    = 32'h0;
    logic [7:0]  rx_plan[$];
    logic [7:0]  legal_ops[8];

    always @(negedge clk) begin
        if (resp_valid === 1'b1) resp_count++;
    end

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference model: which fields each opcode carries on the wire.
    function automatic bit op_legal(input logic [7:0] op);
        return op inside {OP_WRITE, OP_READ, OP_STREAM, OP_TRANSFER, OP_REPEAT,
                          OP_BIND_INTERRUPT, OP_BIND_READ_ADDRESS, OP_BIND_WRITE_ADDRESS};
    endfunction

    function automatic bit op_has_addr(input logic [7:0] op);
        return op inside {OP_WRITE, OP_READ, OP_BIND_INTERRUPT,
                          OP_BIND_READ_ADDRESS, OP_BIND_WRITE_ADDRESS};
    endfunction

    function automatic bit op_has_value(input logic [7:0] op);
        return op inside {OP_WRITE, OP_STREAM};
    endfunction

    // Drive one command and act as the SPI master for it.
    // abort_after >= 0: assert reset while byte number abort_after is offered.
    task automatic run_cmd(input logic [7:0] op, input logic [23:0] addr,
                           input logic [31:0] val, input int tx_wait,
                           input int rx_wait, input bit noise,
                           input int abort_after);
        logic [7:0]  exp_q[$];
        logic [7:0]  rx_q[$];
        logic [7:0]  b;
        logic [31:0] exp_resp;
        int          start_cnt;
        int          idx;

        exp_q = {};
        rx_q  = {};
        if (op_legal(op)) begin
            exp_q.push_back(op);
            if (op_has_addr(op))
                for (int i = 2; i >= 0; i--) exp_q.push_back(addr[i*8 +: 8]);
            if (op_has_value(op))
                for (int i = 3; i >= 0; i--) exp_q.push_back(val[i*8 +: 8]);
        end

        @(negedge clk);
        check_value("cmd_ready_idle", cmd_ready, 1'b1);
        start_cnt       = resp_count;
        cmd_valid       = 1'b1;
        cmd_instruction = op;
        cmd_address     = addr;
        cmd_value       = val;
        @(negedge clk);
        cmd_valid = 1'b0;

        if (!op_legal(op)) begin
            check_value("err_illegal_pulse", err_illegal, 1'b1);
            check_value("illegal_no_tx", spi_tx_valid, 1'b0);
            check_value("illegal_busy", busy, 1'b0);
            @(negedge clk);
            check_value("err_illegal_clear", err_illegal, 1'b0);
            check_value("illegal_no_tx2", spi_tx_valid, 1'b0);
            check_value("illegal_no_resp", resp_count - start_cnt, 0);
            check_value("illegal_resp_kept", resp_value, last_resp);
            $display("[TB] cmd op=%02h illegal -> err_illegal", op);
            return;
        end

        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_after) begin
                #2 rst_n = 1'b0;
                #1;
                check_value("rst_tx_valid", spi_tx_valid, 1'b0);
                check_value("rst_busy", busy, 1'b0);
                check_value("rst_cmd_ready", cmd_ready, 1'b1);
                check_value("rst_tx_byte", spi_tx_byte, 8'h00);
                check_value("rst_resp_value", resp_value, 32'h0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                last_resp = 32'h0;
                repeat (3) @(negedge clk);
                check_value("rst_no_resp", resp_count - start_cnt, 0);
                check_value("rst_no_err", err_illegal, 1'b0);
                $display("[TB] cmd op=%02h aborted by reset at byte %0d", op, i);
                return;
            end
            check_value("tx_valid_rise", spi_tx_valid, 1'b1);
            check_value("tx_byte", spi_tx_byte, exp_q[i]);
            for (int w = 0; w < tx_wait; w++) begin
                if (noise && w == 0) begin
                    spi_rx_valid = 1'b1;
                    spi_rx_byte  = 8'($urandom);
                end
                @(negedge clk);
                spi_rx_valid = 1'b0;
                check_value("tx_valid_hold", spi_tx_valid, 1'b1);
                check_value("tx_byte_stable", spi_tx_byte, exp_q[i]);
            end
            spi_tx_ready = 1'b1;
            if (noise) begin
                // Coincident rx pulse in SEND must be dropped.
                spi_rx_valid = 1'b1;
                spi_rx_byte  = 8'($urandom);
            end
            @(negedge clk);
            spi_tx_ready = 1'b0;
            spi_rx_valid = 1'b0;
            check_value("tx_valid_fall", spi_tx_valid, 1'b0);
            check_value("busy_wait", busy, 1'b1);
            for (int w = 0; w < rx_wait; w++) begin
                @(negedge clk);
                check_value("tx_valid_low_wait", spi_tx_valid, 1'b0);
            end
            b = (rx_plan.size() > 0) ? rx_plan.pop_front() : 8'($urandom);
            rx_q.push_back(b);
            spi_rx_valid = 1'b1;
            spi_rx_byte  = b;
            @(negedge clk);
            spi_rx_valid = 1'b0;
        end

        exp_resp = 32'h0;
        for (int k = 0; k < 4; k++) begin
            idx = rx_q.size() - 4 + k;
            if (idx >= 0) exp_resp[(3-k)*8 +: 8] = rx_q[idx];
        end

        check_value("resp_valid_pulse", resp_valid, 1'b1);
        check_value("resp_value", resp_value, exp_resp);
        check_value("cmd_ready_done", cmd_ready, 1'b0);
        @(negedge clk);
        check_value("resp_valid_clear", resp_valid, 1'b0);
        check_value("cmd_ready_back", cmd_ready, 1'b1);
        check_value("resp_once", resp_count - start_cnt, 1);
        last_resp = exp_resp;
        $display("[TB] cmd op=%02h addr=%06h value=%08h bytes=%0d resp=%08h",
                 op, addr, val, exp_q.size(), resp_value);
    endtask

    task automatic spurious_idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            spi_rx_valid = 1'b1;
            spi_rx_byte  = 8'($urandom);
            spi_tx_ready = 1'b1;
            @(negedge clk);
            spi_rx_valid = 1'b0;
            spi_tx_ready = 1'b0;
            check_value("spur_busy", busy, 1'b0);
            check_value("spur_tx_valid", spi_tx_valid, 1'b0);
            check_value("spur_resp_kept", resp_value, last_resp);
        end
        $display("[TB] spurious idle pulses x%0d -> ignored", cycles);
    endtask

    initial begin
        logic [7:0] op;
        int         r;

        legal_ops = '{OP_WRITE, OP_READ, OP_STREAM, OP_TRANSFER, OP_REPEAT,
                      OP_BIND_INTERRUPT, OP_BIND_READ_ADDRESS, OP_BIND_WRITE_ADDRESS};
        rst_n           = 1'b0;
        cmd_valid       = 1'b0;
        cmd_instruction = 8'h0;
        cmd_address     = 24'h0;
        cmd_value       = 32'h0;
        spi_tx_ready    = 1'b0;
        spi_rx_valid    = 1'b0;
        spi_rx_byte     = 8'h0;

        repeat (2) @(negedge clk);
        check_value("reset_cmd_ready", cmd_ready, 1'b1);
        check_value("reset_tx_valid", spi_tx_valid, 1'b0);
        check_value("reset_tx_byte", spi_tx_byte, 8'h00);
        check_value("reset_resp_valid", resp_valid, 1'b0);
        check_value("reset_resp_value", resp_value, 32'h0);
        check_value("reset_busy", busy, 1'b0);
        check_value("reset_err", err_illegal, 1'b0);
        rst_n = 1'b1;

        // WRITE: rx 01..08 -> response 05060708.
        rx_plan = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_cmd(OP_WRITE, 24'h000010, 32'hDEADBEEF, 0, 0, 1'b0, -1);
        check_value("write_resp_literal", last_resp, 32'h05060708);

        rx_plan = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_cmd(OP_READ, 24'h123456, 32'h0, 1, 1, 1'b0, -1);
        check_value("read_resp_literal", last_resp, 32'hAABBCCDD);

        run_cmd(OP_STREAM, 24'h0, 32'h01020304, 5, 0, 1'b0, -1);

        rx_plan = '{8'h5A};
        run_cmd(OP_TRANSFER, 24'h0, 32'h0, 0, 2, 1'b0, -1);
        check_value("transfer_resp_literal", last_resp, 32'h0000005A);

        run_cmd(8'hFF, 24'hABCDEF, 32'h12345678, 0, 0, 1'b0, -1);

        spurious_idle(2);

        // Reset while the 4th WRITE byte is offered, then a normal READ.
        run_cmd(OP_WRITE, 24'h00BEEF, 32'hCAFEF00D, 1, 1, 1'b0, 3);
        run_cmd(OP_READ, 24'h0A0B0C, 32'h0, 0, 1, 1'b1, -1);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) op = legal_ops[r];
            else       op = 8'($urandom_range(9, 255));
            run_cmd(op, 24'($urandom), $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
            if ((n % 10) == 9) spurious_idle(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
